// File: rtl/oven_pkg.sv
// Shared types and helpers for the oven controller: state encoding,
// button indices and the BCD digit adjust step used by the converter.
package oven_pkg;

  localparam int STATE_W    = 3;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam int BTN_POWER = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_START = 3;
  localparam int BTN_N     = 4;

  typedef enum logic [STATE_W-1:0] {
    OFF     = 3'd0,
    IDLE    = 3'd1,
    PREHEAT = 3'd2,
    BAKE    = 3'd3,
    DONE    = 3'd4
  } oven_state_e;

  // Shift-add-3 correction: any digit of 5 or more gets 3 added before the shift
  function automatic logic [BCD_W-1:0] bcdAdjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// Only the low four decimal digits are kept, so larger values wrap mod 10000.
module bin2bcd_seq
  import oven_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [IN_W-1:0]  bin_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CNT_W = $clog2(IN_W + 1);

  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adjusted;

  assign adjusted = bcdAdjust(bcd_q);

  always_comb begin
    busy_d  = busy_q;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d  = 1'b1;
        cnt_d   = '0;
        shift_d = bin_i;
        bcd_d   = '0;
      end
    end else if (cnt_q == CNT_W'(IN_W)) begin
      busy_d  = 1'b0;
      valid_d = 1'b1;
    end else begin
      bcd_d   = {adjusted[BCD_W-2:0], shift_q[IN_W-1]};
      shift_d = {shift_q[IN_W-2:0], 1'b0};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;

endmodule

// File: rtl/oven_ctrl.sv
// Oven controller: button press detection, one-second tick, thermal model with
// hysteretic heater, preheat/bake/done sequencer and the BCD display feed.
module oven_ctrl
  import oven_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int TEMP_W    = 11,
  parameter int TIME_W    = 12,
  parameter int TEMP_MIN  = 150,
  parameter int TEMP_MAX  = 550,
  parameter int TEMP_INIT = 350,
  parameter int TEMP_STEP = 5,
  parameter int AMBIENT   = 70,
  parameter int HEAT_RATE = 2,
  parameter int COOL_RATE = 1,
  parameter int HYST      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power_n,
  input  logic              up_n,
  input  logic              down_n,
  input  logic              start_n,
  input  logic [TIME_W-1:0] bake_time,
  input  logic              disp_sel,
  output logic [2:0]        state,
  output logic              heater,
  output logic              done,
  output logic [TEMP_W-1:0] cur_temp,
  output logic [15:0]       digits
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SRC_W  = (TEMP_W > TIME_W) ? TEMP_W : TIME_W;
  localparam int TX_W   = TEMP_W + 1;

  localparam logic [TX_W-1:0] T_MIN  = TX_W'(TEMP_MIN);
  localparam logic [TX_W-1:0] T_MAX  = TX_W'(TEMP_MAX);
  localparam logic [TX_W-1:0] T_INIT = TX_W'(TEMP_INIT);
  localparam logic [TX_W-1:0] T_STEP = TX_W'(TEMP_STEP);
  localparam logic [TX_W-1:0] T_AMB  = TX_W'(AMBIENT);
  localparam logic [TX_W-1:0] T_HEAT = TX_W'(HEAT_RATE);
  localparam logic [TX_W-1:0] T_COOL = TX_W'(COOL_RATE);
  localparam logic [TX_W-1:0] T_HYST = TX_W'(HYST);
  localparam logic [TX_W-1:0] T_SAT  = {1'b0, {TEMP_W{1'b1}}};

  logic [BTN_N-1:0] btnRaw, sync1_q, sync2_q, prev_q, press_q;
  logic [1:0]       sampleValid_q;

  assign btnRaw = {start_n, down_n, up_n, power_n};

  // prev_q stays 0 until the synchroniser holds a real post-reset sample, so a
  // button already held at reset release never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      prev_q        <= '0;
      press_q       <= '0;
      sampleValid_q <= '0;
    end else begin
      sync1_q       <= btnRaw;
      sync2_q       <= sync1_q;
      sampleValid_q <= {sampleValid_q[0], 1'b1};
      prev_q        <= sampleValid_q[1] ? sync2_q : '0;
      press_q       <= prev_q & ~sync2_q;
    end
  end

  logic [TICK_W-1:0] tickCnt_q;
  logic              tick;

  assign tick = (tickCnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    tickCnt_q <= '0;
    else if (tick) tickCnt_q <= '0;
    else           tickCnt_q <= tickCnt_q + 1'b1;
  end

  oven_state_e       state_q, state_d;
  logic [TEMP_W-1:0] target_q, target_d;
  logic [TEMP_W-1:0] curTemp_q, curTemp_d;
  logic [TIME_W-1:0] timeLeft_q, timeLeft_d;
  logic              heater_q, heater_d;

  logic [TX_W-1:0]   curX, tgtX, heatSum, coolDiff, upSum, downDiff;
  logic [TEMP_W-1:0] heatedTemp, cooledTemp, raisedTarget, loweredTarget;
  logic              heatOn, heatOff;

  assign curX     = {1'b0, curTemp_q};
  assign tgtX     = {1'b0, target_q};
  assign heatSum  = curX + T_HEAT;
  assign coolDiff = curX - T_COOL;
  assign upSum    = tgtX + T_STEP;
  assign downDiff = tgtX - T_STEP;

  assign heatedTemp    = (heatSum > T_SAT) ? {TEMP_W{1'b1}} : heatSum[TEMP_W-1:0];
  assign cooledTemp    = (curX >= T_AMB + T_COOL) ? coolDiff[TEMP_W-1:0] : T_AMB[TEMP_W-1:0];
  assign raisedTarget  = (upSum > T_MAX) ? T_MAX[TEMP_W-1:0] : upSum[TEMP_W-1:0];
  assign loweredTarget = (tgtX < T_MIN + T_STEP) ? T_MIN[TEMP_W-1:0] : downDiff[TEMP_W-1:0];

  assign heatOn  = (curX + T_HYST) < tgtX;
  assign heatOff = curX >= tgtX;

  // The thermal model runs in every state and uses the heater value from before the tick.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    curTemp_d  = curTemp_q;
    timeLeft_d = timeLeft_q;
    heater_d   = 1'b0;

    if (tick) begin
      curTemp_d = heater_q ? heatedTemp : cooledTemp;
    end

    if (press_q[BTN_POWER]) begin
      state_d = (state_q == OFF) ? IDLE : OFF;
    end else begin
      case (state_q)
        OFF: ;
        IDLE: begin
          if (press_q[BTN_START]) begin
            state_d    = PREHEAT;
            timeLeft_d = bake_time;
          end
          if (press_q[BTN_UP] && !press_q[BTN_DOWN]) begin
            target_d = raisedTarget;
          end else if (press_q[BTN_DOWN] && !press_q[BTN_UP]) begin
            target_d = loweredTarget;
          end
        end
        PREHEAT: begin
          if (tick && heatOff) state_d = BAKE;
        end
        BAKE: begin
          if (tick) begin
            if (timeLeft_q == '0) state_d = DONE;
            else                  timeLeft_d = timeLeft_q - 1'b1;
          end
        end
        DONE: begin
          if (press_q[BTN_START]) state_d = IDLE;
        end
        default: state_d = OFF;
      endcase
    end

    // Heater follows the state being entered so a power-off drops it immediately.
    if (state_d == PREHEAT || state_d == BAKE) begin
      if (heatOn)       heater_d = 1'b1;
      else if (heatOff) heater_d = 1'b0;
      else              heater_d = heater_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      target_q   <= T_INIT[TEMP_W-1:0];
      curTemp_q  <= T_AMB[TEMP_W-1:0];
      timeLeft_q <= '0;
      heater_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      curTemp_q  <= curTemp_d;
      timeLeft_q <= timeLeft_d;
      heater_q   <= heater_d;
    end
  end

  logic [SRC_W-1:0] srcVal, lastSrc_q;
  logic [BCD_W-1:0] convBcd, digits_q;
  logic             convBusy, convValid, convStart;

  always_comb begin
    if (disp_sel)             srcVal = SRC_W'(timeLeft_q);
    else if (state_q == BAKE) srcVal = SRC_W'(curTemp_q);
    else                      srcVal = SRC_W'(target_q);
  end

  assign convStart = !convBusy && (srcVal != lastSrc_q);

  bin2bcd_seq #(
    .IN_W (SRC_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (convStart),
    .bin_i   (srcVal),
    .busy_o  (convBusy),
    .valid_o (convValid),
    .bcd_o   (convBcd)
  );

  // digits only changes on a completed conversion, never mid-shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastSrc_q <= '0;
      digits_q  <= '0;
    end else begin
      if (convStart) lastSrc_q <= srcVal;
      if (convValid) digits_q  <= convBcd;
    end
  end

  assign state    = state_q;
  assign heater   = heater_q;
  assign done     = (state_q == DONE);
  assign cur_temp = curTemp_q;
  assign digits   = digits_q;

endmodule

// File: tb/tb_oven_ctrl.sv
// Randomised bench for oven_ctrl: a reference model pushes the expected outputs
// for every clock edge into a queue that a separate monitor pops and checks.
module tb_oven_ctrl;

   localparam int TD        = 4;
   localparam int TEMP_W    = 11;
   localparam int TIME_W    = 12;
   localparam int TEMP_MIN  = 80;
   localparam int TEMP_MAX  = 550;
   localparam int TEMP_INIT = 350;
   localparam int TEMP_STEP = 5;
   localparam int AMBIENT   = 70;
   localparam int HEAT_RATE = 2;
   localparam int COOL_RATE = 1;
   localparam int HYST      = 2;
   localparam int TEMP_SAT  = (1 << TEMP_W) - 1;
   localparam int CONV_LAT  = ((TEMP_W > TIME_W) ? TEMP_W : TIME_W) + 2;

   localparam int M_POWER = 1;
   localparam int M_UP    = 2;
   localparam int M_DOWN  = 4;
   localparam int M_START = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              power_n, up_n, down_n, start_n;
   logic [TIME_W-1:0] bake_time;
   logic              disp_sel;
   logic [2:0]        state;
   logic              heater;
   logic              done;
   logic [TEMP_W-1:0] cur_temp;
   logic [15:0]       digits;

   oven_ctrl #(
      .TICK_DIV (TD),        .TEMP_W (TEMP_W),       .TIME_W (TIME_W),
      .TEMP_MIN (TEMP_MIN),  .TEMP_MAX (TEMP_MAX),   .TEMP_INIT (TEMP_INIT),
      .TEMP_STEP (TEMP_STEP), .AMBIENT (AMBIENT),    .HEAT_RATE (HEAT_RATE),
      .COOL_RATE (COOL_RATE), .HYST (HYST)
   ) dut (
      .clk (clk), .rst_n (rst_n), .power_n (power_n), .up_n (up_n),
      .down_n (down_n), .start_n (start_n), .bake_time (bake_time),
      .disp_sel (disp_sel), .state (state), .heater (heater), .done (done),
      .cur_temp (cur_temp), .digits (digits)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int htr;
      int dn;
      int cur;
      int dig;
   } exp_t;

   exp_t expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;

   // Reference model state
   int mState, mTarget, mCur, mTime, mHeater, mCyc;
   int mHist[4][4];
   int convRem, convVal, mLast, mDigits;

   function automatic int toBcd(input int v);
      int w;
      w = v % 10000;
      return (((w / 1000) % 10) << 12) | (((w / 100) % 10) << 8) |
             (((w / 10) % 10) << 4) | (w % 10);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      assertCount++;
      if (act !== expv) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, expv, expv, $time);
      end
   endtask

   // Model of the whole oven, advanced once per clock edge from the spec's rules.
   always @(posedge clk) begin : refModel
      exp_t e;
      int   samp[4];
      int   press[4];
      int   tickNow, src;
      int   nState, nTarget, nTime, nCur, nHeater;
      if (!rst_n) begin
         mState = 0; mTarget = TEMP_INIT; mCur = AMBIENT; mTime = 0; mHeater = 0;
         mCyc = 0; convRem = 0; convVal = 0; mLast = 0; mDigits = 0;
         for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) mHist[b][k] = 0;
      end else begin
         samp[0] = int'(power_n); samp[1] = int'(up_n);
         samp[2] = int'(down_n);  samp[3] = int'(start_n);
         // A press reaches the FSM four edges after the first low sample, and only
         // after the button has been seen released since reset.
         for (int b = 0; b < 4; b++) begin
            press[b] = (mHist[b][3] == 1 && mHist[b][2] == 0) ? 1 : 0;
            mHist[b][3] = mHist[b][2];
            mHist[b][2] = mHist[b][1];
            mHist[b][1] = mHist[b][0];
            mHist[b][0] = samp[b];
         end
         tickNow = ((mCyc % TD) == TD - 1) ? 1 : 0;
         mCyc++;

         src = disp_sel ? mTime : ((mState == 3) ? mCur : mTarget);
         if (convRem > 0) begin
            convRem--;
            if (convRem == 0) mDigits = toBcd(convVal);
         end
         if (convRem == 0 && src != mLast) begin
            convRem = CONV_LAT;
            convVal = src;
            mLast   = src;
         end

         nState = mState; nTarget = mTarget; nTime = mTime; nCur = mCur;
         if (tickNow == 1) begin
            if (mHeater == 1) nCur = (mCur + HEAT_RATE > TEMP_SAT) ? TEMP_SAT : mCur + HEAT_RATE;
            else              nCur = (mCur - COOL_RATE < AMBIENT) ? AMBIENT : mCur - COOL_RATE;
         end
         if (press[0] == 1) begin
            nState = (mState == 0) ? 1 : 0;
         end else begin
            case (mState)
               1: begin
                  if (press[3] == 1) begin
                     nState = 2;
                     nTime  = int'(bake_time);
                  end
                  if (press[1] == 1 && press[2] == 0)
                     nTarget = (mTarget + TEMP_STEP > TEMP_MAX) ? TEMP_MAX : mTarget + TEMP_STEP;
                  else if (press[2] == 1 && press[1] == 0)
                     nTarget = (mTarget - TEMP_STEP < TEMP_MIN) ? TEMP_MIN : mTarget - TEMP_STEP;
               end
               2: if (tickNow == 1 && mCur >= mTarget) nState = 3;
               3: if (tickNow == 1) begin
                     if (mTime == 0) nState = 4;
                     else            nTime = mTime - 1;
                  end
               4: if (press[3] == 1) nState = 1;
               default: ;
            endcase
         end
         if (nState == 2 || nState == 3) begin
            if (mCur < mTarget - HYST) nHeater = 1;
            else if (mCur >= mTarget)  nHeater = 0;
            else                       nHeater = mHeater;
         end else begin
            nHeater = 0;
         end
         mState = nState; mTarget = nTarget; mTime = nTime; mCur = nCur; mHeater = nHeater;
      end
      e.st  = mState;
      e.htr = mHeater;
      e.dn  = (mState == 4) ? 1 : 0;
      e.cur = mCur;
      e.dig = mDigits;
      expQ.push_back(e);
   end

   // Monitor: compares the DUT against the oldest expected record, mid-cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("state",    32'(state),    e.st);
         checkOutput("heater",   32'(heater),   e.htr);
         checkOutput("done",     32'(done),     e.dn);
         checkOutput("cur_temp", 32'(cur_temp), e.cur);
         checkOutput("digits",   32'(digits),   e.dig);
      end
   end

   task automatic applyStimulus(input int mask, input int hold, input int gap);
      @(negedge clk);
      power_n = ((mask & M_POWER) != 0) ? 1'b0 : 1'b1;
      up_n    = ((mask & M_UP)    != 0) ? 1'b0 : 1'b1;
      down_n  = ((mask & M_DOWN)  != 0) ? 1'b0 : 1'b1;
      start_n = ((mask & M_START) != 0) ? 1'b0 : 1'b1;
      repeat (hold) @(negedge clk);
      power_n = 1'b1; up_n = 1'b1; down_n = 1'b1; start_n = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic waitState(input int st, input int maxCyc);
      int n;
      n = 0;
      while (state !== 3'(st) && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait for state", 32'(state), st);
   endtask

   initial begin : stimulus
      int op;
      rst_n = 1'b0; power_n = 1'b1; up_n = 1'b1; down_n = 1'b1;
      start_n = 1'b0; bake_time = 12'd3; disp_sel = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      start_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] power on, three up presses");
      applyStimulus(M_POWER, 2, 4);
      repeat (3) applyStimulus(M_UP, 2, 3);
      repeat (20) @(negedge clk);

      $display("[TB] saturate high, simultaneous up/down");
      repeat (25) applyStimulus(M_UP, 1, 2);
      repeat (20) @(negedge clk);
      repeat (2) applyStimulus(M_UP | M_DOWN, 2, 4);
      repeat (20) @(negedge clk);

      $display("[TB] lower target to the floor");
      repeat (100) applyStimulus(M_DOWN, 1, 2);
      repeat (20) @(negedge clk);

      $display("[TB] bake cycle with bake_time 3");
      bake_time = 12'd3;
      applyStimulus(M_START, 2, 2);
      waitState(4, 400);
      repeat (10) @(negedge clk);
      applyStimulus(M_START, 2, 10);

      $display("[TB] hysteresis in bake, then power off");
      bake_time = 12'd20;
      applyStimulus(M_START, 2, 2);
      waitState(3, 400);
      repeat (30) @(negedge clk);
      disp_sel = 1'b1;
      repeat (30) @(negedge clk);
      disp_sel = 1'b0;
      applyStimulus(M_POWER, 2, 80);

      $display("[TB] reset during preheat");
      applyStimulus(M_POWER, 2, 4);
      applyStimulus(M_START, 2, 2);
      waitState(2, 50);
      repeat (5) @(negedge clk);
      start_n = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      start_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] random phase");
      applyStimulus(M_POWER, 2, 4);
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 4) == 0) disp_sel = 1'($urandom_range(0, 1));
         bake_time = 12'($urandom_range(0, 6));
         op = $urandom_range(0, 10);
         case (op)
            0:       applyStimulus(M_POWER, $urandom_range(1, 3), $urandom_range(1, 8));
            1, 2, 3: applyStimulus(M_UP, $urandom_range(1, 3), $urandom_range(1, 8));
            4, 5:    applyStimulus(M_DOWN, $urandom_range(1, 3), $urandom_range(1, 8));
            6, 7:    applyStimulus(M_START, $urandom_range(1, 3), $urandom_range(1, 8));
            8:       applyStimulus(M_UP | M_DOWN, $urandom_range(1, 3), $urandom_range(1, 8));
            9:       repeat ($urandom_range(5, 40)) @(negedge clk);
            default: begin
               if ($urandom_range(0, 7) == 0) begin
                  @(negedge clk);
                  rst_n = 1'b0;
                  @(negedge clk);
                  rst_n = 1'b1;
               end else begin
                  repeat (3) @(negedge clk);
               end
            end
         endcase
      end
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule
